chacha20_poly1305_bus_master: RTL and testbench

Bus initiator for the `chacha20_poly1305_bus` register interface. It accepts one job on a valid/ready handshake: a 256-bit key, a 96-bit nonce and a 64-bit data block. It drives the `cs`/`we`/`address`/`write_data` bus to load the job, issue init and next, poll status and read back the 64-bit result, then returns the result on a response handshake. It sits between a host-side command source and the crypto core, and replaces testbench-style register poking with hardware sequencing.

---
 rtl/chacha20_poly1305_bus_master.sv | 210 +++++++++++++++++++++
 tb/tb_chacha20_poly1305_bus_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_poly1305_bus_master.sv
// Bus initiator for the chacha20_poly1305_bus register interface: loads one key/nonce/data job,
// runs init/next, polls status and returns the 64-bit result. CHACHA_BUS_MASTER_TIMEOUT_EN bounds polling.
module chacha20_poly1305_bus_master #(
  parameter int unsigned INIT_GAP = 2,
  parameter int unsigned POLL_GAP = 4
`ifdef CHACHA_BUS_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 1024
`endif
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [63:0]  data,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [63:0]  result,
  output logic         resp_error,
  output logic         busy,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data
);

  localparam logic [7:0] AddrCtrl   = 8'h08;
  localparam logic [7:0] AddrStatus = 8'h09;

  typedef enum logic [2:0] {
    StIdle, StLoad, StInit, StNext, StPoll, StRead, StFin, StResp
  } state_e;

  state_e        state_q, state_d, next_q, next_d;
  logic          phase_q, phase_d;  // 0: strobe cycle, 1: recovery/gap cycles
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   gap_q, gap_d;
  logic [255:0]  key_q, key_d;
  logic [95:0]   nonce_q, nonce_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   result_q, result_d;
  logic [12:0][31:0] words;

  // words[12] is the key MSW, so load index i maps to words[12 - i]
  assign words = {key_q, nonce_q, data_q};

`ifdef CHACHA_BUS_MASTER_TIMEOUT_EN
  localparam int unsigned PollW = $clog2(TIMEOUT + 1);
  logic [PollW-1:0] poll_q, poll_d;
  logic             error_q, error_d;
  assign resp_error = error_q;
`else
  assign resp_error = 1'b0;
`endif

  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign resp_valid  = (state_q == StResp);
  assign result      = result_q;

  always_comb begin
    state_d    = state_q;
    next_d     = next_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    data_d     = data_q;
    result_d   = result_q;
`ifdef CHACHA_BUS_MASTER_TIMEOUT_EN
    poll_d     = poll_q;
    error_d    = error_q;
`endif
    cs         = 1'b0;
    we         = 1'b0;
    address    = '0;
    write_data = '0;

    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          key_d    = key;
          nonce_d  = nonce;
          data_d   = data;
          result_d = '0;
          idx_d    = '0;
          phase_d  = 1'b0;
          state_d  = StLoad;
`ifdef CHACHA_BUS_MASTER_TIMEOUT_EN
          poll_d   = '0;
          error_d  = 1'b0;
`endif
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: begin
        if (!phase_q) begin
          cs      = 1'b1;
          phase_d = 1'b1;
          gap_d   = '0;
          unique case (state_q)
            StLoad: begin
              we         = 1'b1;
              if (idx_q < 4'd8)       address = 8'h10 + {4'h0, idx_q};
              else if (idx_q < 4'd11) address = 8'h18 + {4'h0, idx_q};
              else                    address = 8'h25 + {4'h0, idx_q};
              write_data = words[4'd12 - idx_q];
              idx_d      = idx_q + 4'd1;
              next_d     = (idx_q == 4'd12) ? StInit : StLoad;
            end
            StInit: begin
              we         = 1'b1;
              address    = AddrCtrl;
              write_data = 32'h1;
              gap_d      = 16'(INIT_GAP);
              next_d     = StNext;
            end
            StNext: begin
              we         = 1'b1;
              address    = AddrCtrl;
              write_data = 32'h2;
              next_d     = StPoll;
            end
            StPoll: begin
              address = AddrStatus;
              if (read_data[0]) begin
                idx_d  = '0;
                next_d = StRead;
              end else begin
                gap_d  = 16'(POLL_GAP);
                next_d = StPoll;
`ifdef CHACHA_BUS_MASTER_TIMEOUT_EN
                poll_d = poll_q + 1'b1;
                if (poll_d == PollW'(TIMEOUT)) begin
                  error_d  = 1'b1;
                  result_d = '0;
                  gap_d    = '0;
                  next_d   = StFin;
                end
`endif
              end
            end
            StRead: begin
              address = {7'b0100000, idx_q[0]};
              if (!idx_q[0]) result_d[63:32] = read_data;
              else           result_d[31:0]  = read_data;
              idx_d   = idx_q + 4'd1;
              next_d  = idx_q[0] ? StFin : StRead;
            end
            StFin: begin
              we         = 1'b1;
              address    = AddrCtrl;
              write_data = 32'h4;
              next_d     = StResp;
            end
            default: ;
          endcase
        end else if (gap_q != '0) begin
          gap_d = gap_q - 16'd1;
        end else begin
          phase_d = 1'b0;
          state_d = next_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      next_q   <= StIdle;
      phase_q  <= 1'b0;
      idx_q    <= '0;
      gap_q    <= '0;
      key_q    <= '0;
      nonce_q  <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      next_q   <= next_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      key_q    <= key_d;
      nonce_q  <= nonce_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

`ifdef CHACHA_BUS_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_q  <= '0;
      error_q <= 1'b0;
    end else begin
      poll_q  <= poll_d;
      error_q <= error_d;
    end
  end
`endif

endmodule

// File: tb/tb_chacha20_poly1305_bus_master.sv
// Self-checking bench for chacha20_poly1305_bus_master: register-slave model, bus logger and
// directed plus randomized jobs compared against expectations derived from the job contents.
module tb_chacha20_poly1305_bus_master;

  localparam int InitGap = 2;
  localparam int PollGap = 4;
  localparam int MinLat  = 41;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [63:0]  data = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [63:0]  result;
  logic         resp_error;
  logic         busy;
  logic         cs;
  logic         we;
  logic [7:0]   address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;

  always #5 clk = ~clk;

  chacha20_poly1305_bus_master #(
    .INIT_GAP(InitGap),
    .POLL_GAP(PollGap)
`ifdef CHACHA_BUS_MASTER_TIMEOUT_EN
    ,
    .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
    .key(key), .nonce(nonce), .data(data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .resp_error(resp_error), .busy(busy), .cs(cs), .we(we),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  // Slave model and bus logger
  typedef struct { logic we; logic [7:0] a; logic [31:0] d; int c; } acc_t;
  acc_t        log_q[$];
  int          cyc = 0;
  int          polls = 0;
  int          viol = 0;
  logic        cs_prev = 1'b0;
  int          ready_at = 0;
  int          polls_base = 0;
  int          log_base = 0;
  logic [31:0] res_hi = '0;
  logic [31:0] res_lo = '0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cs_prev <= cs;
    if (cs && cs_prev) viol <= viol + 1;
    if (cs) log_q.push_back(acc_t'{we, address, (we ? write_data : read_data), cyc});
    if (cs && !we && address == 8'h09) polls <= polls + 1;
  end

  always_comb begin
    read_data = 32'h0;
    if (cs && !we) begin
      case (address)
        8'h09:   read_data = {31'h0, (ready_at != 0) && (polls - polls_base + 1 >= ready_at)};
        8'h40:   read_data = res_hi;
        8'h41:   read_data = res_lo;
        default: read_data = 32'hdead_beef;
      endcase
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic setup_slave(input int ready, input logic [31:0] rh, input logic [31:0] rl);
    ready_at   = ready;
    res_hi     = rh;
    res_lo     = rl;
    polls_base = polls;
    log_base   = log_q.size();
  endtask

  task automatic accept_job(input logic [255:0] k, input logic [95:0] n, input logic [63:0] d);
    @(negedge clk);
    key = k; nonce = n; data = d; start_valid = 1'b1;
    check("start_ready_idle", start_ready, 1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    // Changing inputs after capture must not affect the job
    key = rnd256(); nonce = rnd256()[95:0]; data = {$urandom, $urandom};
  endtask

  task automatic wait_resp(output int lat);
    int bad;
    bad = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid && (start_ready || !busy)) bad++;
    end while (!resp_valid && lat < 3000);
    check("resp_seen", resp_valid, 1);
    check("busy_during_job", bad, 0);
  endtask

  task automatic check_bus(input logic [255:0] k, input logic [95:0] n, input logic [63:0] d,
                           input int exp_polls, input bit exp_err);
    logic [415:0] blob;
    logic [39:0]  exp_w[$];
    logic [7:0]   a;
    int nw, npoll, nres, bad_gap, c_init, c_next, last_poll;
    blob = {k, n, d};
    for (int i = 0; i < 13; i++) begin
      if (i < 8)       a = 8'(32'h10 + i);
      else if (i < 11) a = 8'(32'h20 + i - 8);
      else             a = 8'(32'h30 + i - 11);
      exp_w.push_back({a, blob[415 - 32*i -: 32]});
    end
    exp_w.push_back({8'h08, 32'h1});
    exp_w.push_back({8'h08, 32'h2});
    exp_w.push_back({8'h08, 32'h4});
    nw = 0; npoll = 0; nres = 0; bad_gap = 0; c_init = 0; c_next = 0; last_poll = -1;
    for (int j = log_base; j < log_q.size(); j++) begin
      if (log_q[j].we) begin
        if (nw < 16) check($sformatf("write%0d", nw), {log_q[j].a, log_q[j].d}, exp_w[nw]);
        if (log_q[j].a == 8'h08 && log_q[j].d == 32'h1) c_init = log_q[j].c;
        if (log_q[j].a == 8'h08 && log_q[j].d == 32'h2) c_next = log_q[j].c;
        nw++;
      end else if (log_q[j].a == 8'h09) begin
        npoll++;
        if (last_poll >= 0 && log_q[j].c - last_poll != PollGap + 2) bad_gap++;
        last_poll = log_q[j].c;
      end else begin
        nres++;
      end
    end
    check("write_count", nw, 16);
    check("poll_count", npoll, exp_polls);
    check("result_reads", nres, exp_err ? 0 : 2);
    check("init_next_gap", c_next - c_init, InitGap + 2);
    check("poll_gap", bad_gap, 0);
    check("cs_consecutive", viol, 0);
  endtask

  task automatic finish_resp(input int bp);
    bit ok;
    logic [63:0] r0;
    ok = 1'b1;
    r0 = result;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!resp_valid || result !== r0 || start_ready) ok = 1'b0;
    end
    if (bp > 0) check("backpressure_hold", ok, 1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("resp_done", {resp_valid, start_ready}, 2'b01);
  endtask

  initial begin
    logic [255:0] k, k2;
    logic [95:0]  n, n2;
    logic [63:0]  d, d2, r;
    int           lat, rdy, pulses;

    repeat (3) @(negedge clk);
    check("reset_start_ready", start_ready, 1);
    check("reset_ctrl", {busy, cs, we, resp_valid, resp_error}, 0);
    check("reset_bus", {address, write_data}, 0);
    check("reset_result", result, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic job with response backpressure
    k = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_deadbeef_feedface;
    n = 96'h01010101_02020202_03030303;
    d = 64'haaaaaaaa_bbbbbbbb;
    setup_slave(3, 32'h12345678, 32'h9abcdef0);
    accept_job(k, n, d);
    wait_resp(lat);
    check("basic_latency", lat, MinLat + 2 * (PollGap + 2));
    check("basic_result", result, 64'h12345678_9abcdef0);
    check("basic_error", resp_error, 0);
    check_bus(k, n, d, 3, 1'b0);
    finish_resp(10);

    // Back-to-back: second job offered while the first response is being taken
    k = rnd256(); n = rnd256()[95:0]; d = {$urandom, $urandom}; r = {$urandom, $urandom};
    setup_slave(2, r[63:32], r[31:0]);
    accept_job(k, n, d);
    wait_resp(lat);
    check("b2b_a_latency", lat, MinLat + (PollGap + 2));
    check("b2b_a_result", result, r);
    check_bus(k, n, d, 2, 1'b0);
    k2 = rnd256(); n2 = rnd256()[95:0]; d2 = {$urandom, $urandom}; r = {$urandom, $urandom};
    @(negedge clk);
    key = k2; nonce = n2; data = d2; start_valid = 1'b1; resp_ready = 1'b1;
    setup_slave(1, r[63:32], r[31:0]);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("b2b_idle_cycle", {resp_valid, start_ready, cs}, 3'b010);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(negedge clk);
    check("b2b_first_cs", {cs, we, address, write_data}, {1'b1, 1'b1, 8'h10, k2[255:224]});
    wait_resp(lat);
    check("b2b_b_result", result, r);
    check_bus(k2, n2, d2, 1, 1'b0);
    finish_resp(0);

`ifdef CHACHA_BUS_MASTER_TIMEOUT_EN
    // Status never ready: abort after 8 polls
    k = rnd256(); n = rnd256()[95:0]; d = {$urandom, $urandom};
    setup_slave(0, $urandom, $urandom);
    accept_job(k, n, d);
    wait_resp(lat);
    check("timeout_error", resp_error, 1);
    check("timeout_result", result, 0);
    check_bus(k, n, d, 8, 1'b1);
    finish_resp(0);
`endif

    // Reset during the 5th load write
    k = rnd256(); n = rnd256()[95:0]; d = {$urandom, $urandom};
    setup_slave(1, $urandom, $urandom);
    accept_job(k, n, d);
    repeat (9) @(negedge clk);
    check("rst_5th_write", {cs, address}, {1'b1, 8'h14});
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_async_cs", {cs, we}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_idle", {start_ready, busy}, 2'b10);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("rst_no_resp", pulses, 0);

    // Randomized jobs
    for (int t = 0; t < 3; t++) begin
      k = rnd256(); n = rnd256()[95:0]; d = {$urandom, $urandom}; r = {$urandom, $urandom};
      rdy = int'($urandom_range(1, 4));
      setup_slave(rdy, r[63:32], r[31:0]);
      accept_job(k, n, d);
      wait_resp(lat);
      check($sformatf("rnd%0d_latency", t), lat, MinLat + (rdy - 1) * (PollGap + 2));
      check($sformatf("rnd%0d_result", t), result, r);
      check($sformatf("rnd%0d_error", t), resp_error, 0);
      check_bus(k, n, d, rdy, 1'b0);
      finish_resp(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
